// File: rtl/snn_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_axi_pkg
// Brief    : Shared AXI4-Lite read-side constants and FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package snn_axi_pkg;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;

  localparam logic [31:0] OFF_STATUS   = 32'h0000_0000;
  localparam logic [31:0] OFF_RESULT   = 32'h0000_0004;
  localparam logic [31:0] OFF_CNT_BASE = 32'h0000_0100;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_rd_channel.sv
`default_nettype none
// ============================================================================
// Module   : axil_rd_channel
// Brief    : AR/R handshake FSM holding one response until the host takes it.
// Revision : 1.0 - initial release
// ============================================================================
module axil_rd_channel
  import snn_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ar_valid_i,
  output logic        ar_ready_o,
  input  logic [31:0] rd_data_i,
  input  logic [1:0]  rd_resp_i,
  output logic        r_valid_o,
  output logic [31:0] r_data_o,
  output logic [1:0]  r_resp_o,
  input  logic        r_ready_i,
  output logic        ar_fire_o,
  output logic        r_fire_o
);

  rd_state_t   state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  resp_q, resp_d;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    resp_d     = resp_q;
    ar_fire_o  = 1'b0;
    r_fire_o   = 1'b0;
    ar_ready_o = (state_q == RD_IDLE);
    r_valid_o  = (state_q == RD_RESP);
    case (state_q)
      RD_IDLE: begin
        if (ar_valid_i) begin
          ar_fire_o = 1'b1;
          data_d    = rd_data_i;
          resp_d    = rd_resp_i;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_ready_i) begin
          r_fire_o = 1'b1;
          state_d  = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      data_q  <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  assign r_data_o = data_q;
  assign r_resp_o = resp_q;

endmodule
`default_nettype wire

// File: rtl/axi_out_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : axi_out_result_reader
// Brief    : AXI4-Lite read responder returning the snapshotted SNN result.
// Revision : 1.0 - initial release
// ============================================================================
module axi_out_result_reader
  import snn_axi_pkg::*;
#(
  parameter int          N_OUT     = 10,
  parameter int          CLASS_W   = 4,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
)(
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [31:0]            ARADDR,
  input  logic [2:0]             ARPROT,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [31:0]            RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic                   infer_busy_i,
  input  logic                   infer_done_i,
  input  logic [CLASS_W-1:0]     infer_class_i,
  input  logic [N_OUT*CNT_W-1:0] spike_cnt_i,
  output logic                   result_irq_o
);

  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                rd_is_result_q, rd_is_result_d;
  logic [CLASS_W-1:0]  class_q, class_d;
  logic [CNT_W-1:0]    cnt_q [N_OUT];
  logic [CNT_W-1:0]    cnt_d [N_OUT];

  logic [31:0] offset;
  logic [31:0] word_idx;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        hit_result;
  logic        ar_fire;
  logic        r_fire;
  logic        clear_now;
  logic        unused_ok;

  assign unused_ok = ^ARPROT;

  // Address decode against the live snapshot; the channel latches it on acceptance.
  always_comb begin
    offset     = ARADDR - BASE_ADDR;
    word_idx   = (offset - OFF_CNT_BASE) >> 2;
    rd_data    = '0;
    rd_resp    = RESP_SLVERR;
    hit_result = 1'b0;
    if ((ARADDR >= BASE_ADDR) && (ARADDR[1:0] == 2'b00)) begin
      if (offset == OFF_STATUS) begin
        rd_data = {29'b0, overrun_q, done_q, infer_busy_i};
        rd_resp = RESP_OKAY;
      end else if (offset == OFF_RESULT) begin
        rd_data    = 32'(class_q);
        rd_resp    = RESP_OKAY;
        hit_result = 1'b1;
      end else if ((offset >= OFF_CNT_BASE) &&
                   (offset < OFF_CNT_BASE + 32'(4 * N_OUT))) begin
        for (int i = 0; i < N_OUT; i++) begin
          if (word_idx == 32'(i)) rd_data = 32'(cnt_q[i]);
        end
        rd_resp = RESP_OKAY;
      end
    end
  end

  axil_rd_channel u_rd_channel (
    .clk        (ACLK),
    .rst        (ARESET),
    .ar_valid_i (ARVALID),
    .ar_ready_o (ARREADY),
    .rd_data_i  (rd_data),
    .rd_resp_i  (rd_resp),
    .r_valid_o  (RVALID),
    .r_data_o   (RDATA),
    .r_resp_o   (RRESP),
    .r_ready_i  (RREADY),
    .ar_fire_o  (ar_fire),
    .r_fire_o   (r_fire)
  );

  assign clear_now = r_fire && rd_is_result_q;

  // A new result in the same cycle as a read-clear wins: done stays set, overrun drops.
  always_comb begin
    done_d         = done_q;
    overrun_d      = overrun_q;
    class_d        = class_q;
    cnt_d          = cnt_q;
    rd_is_result_d = rd_is_result_q;
    if (ar_fire) rd_is_result_d = hit_result;
    if (clear_now) begin
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end
    if (infer_done_i) begin
      class_d = infer_class_i;
      for (int i = 0; i < N_OUT; i++) cnt_d[i] = spike_cnt_i[i*CNT_W +: CNT_W];
      if (done_q && !clear_now) overrun_d = 1'b1;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      rd_is_result_q <= 1'b0;
      class_q        <= '0;
      cnt_q          <= '{default: '0};
    end else begin
      done_q         <= done_d;
      overrun_q      <= overrun_d;
      rd_is_result_q <= rd_is_result_d;
      class_q        <= class_d;
      cnt_q          <= cnt_d;
    end
  end

  assign result_irq_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_out_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_out_result_reader
// Brief    : Self-checking bench with a behavioural register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_out_result_reader;

  localparam int          N_OUT   = 10;
  localparam int          CLASS_W = 4;
  localparam int          CNT_W   = 16;
  localparam logic [31:0] BASE    = 32'h0000_2000;

  logic                   ACLK = 1'b0;
  logic                   ARESET;
  logic [31:0]            ARADDR;
  logic [2:0]             ARPROT;
  logic                   ARVALID;
  logic                   ARREADY;
  logic [31:0]            RDATA;
  logic [1:0]             RRESP;
  logic                   RVALID;
  logic                   RREADY;
  logic                   infer_busy_i;
  logic                   infer_done_i;
  logic [CLASS_W-1:0]     infer_class_i;
  logic [N_OUT*CNT_W-1:0] spike_cnt_i;
  logic                   result_irq_o;

  int checks   = 0;
  int failures = 0;

  bit          m_done, m_ovr;
  int unsigned m_class;
  int unsigned m_cnt    [N_OUT];
  int unsigned next_cnt [N_OUT];

  always #5 ACLK = ~ACLK;

  axi_out_result_reader #(
    .N_OUT(N_OUT), .CLASS_W(CLASS_W), .CNT_W(CNT_W), .BASE_ADDR(BASE)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP),
    .RVALID(RVALID), .RREADY(RREADY), .infer_busy_i(infer_busy_i),
    .infer_done_i(infer_done_i), .infer_class_i(infer_class_i),
    .spike_cnt_i(spike_cnt_i), .result_irq_o(result_irq_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_done = 0; m_ovr = 0; m_class = 0;
    for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_snapshot(input int unsigned cls);
    if (m_done) m_ovr = 1;
    m_done  = 1;
    m_class = cls;
    for (int i = 0; i < N_OUT; i++) m_cnt[i] = next_cnt[i];
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                     output logic [1:0] r, output bit clr);
    logic [31:0] off;
    d = 32'd0; r = 2'b10; clr = 0;
    if (a < BASE || (a % 4) != 0) return;
    off = a - BASE;
    if (off == 0) begin
      d = {29'd0, m_ovr, m_done, infer_busy_i}; r = 2'b00;
    end else if (off == 4) begin
      d = m_class; r = 2'b00; clr = 1;
    end else if (off >= 256 && off < 256 + 4 * N_OUT) begin
      d = m_cnt[(off - 256) / 4]; r = 2'b00;
    end
  endfunction

  // ---------------- stimulus drivers ----------------
  task automatic randomize_counts();
    for (int i = 0; i < N_OUT; i++) next_cnt[i] = $urandom_range(0, 16'hFFFF);
  endtask

  task automatic stage_done_inputs(input int unsigned cls);
    infer_class_i = CLASS_W'(cls);
    for (int i = 0; i < N_OUT; i++) spike_cnt_i[i*CNT_W +: CNT_W] = CNT_W'(next_cnt[i]);
  endtask

  task automatic pulse_done(input int unsigned cls);
    @(negedge ACLK);
    stage_done_inputs(cls);
    infer_done_i = 1'b1;
    @(posedge ACLK);
    model_snapshot(cls);
    @(negedge ACLK);
    infer_done_i = 1'b0;
  endtask

  // One read transaction; ok drops on any protocol irregularity or timeout.
  task automatic axi_read(input logic [31:0] addr, input int stall, input bit pulse_at_hs,
                          output logic [31:0] data, output logic [1:0] resp, output bit ok);
    int n;
    ok = 1;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1; RREADY = (stall == 0);
    n = 0;
    while (ARREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (ARREADY !== 1'b1) ok = 0;
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
    if (RVALID !== 1'b1 || ARREADY !== 1'b0) ok = 0;
    data = RDATA; resp = RRESP;
    for (int i = 0; i < stall; i++) begin
      @(negedge ACLK);
      if (RVALID !== 1'b1 || ARREADY !== 1'b0 || RDATA !== data || RRESP !== resp) ok = 0;
    end
    RREADY = 1'b1;
    if (pulse_at_hs) infer_done_i = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 1'b0;
    infer_done_i = 1'b0;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) ok = 0;
  endtask

  task automatic apply_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0 || RDATA !== 32'd0 ||
        RRESP !== 2'b00 || result_irq_o !== 1'b0) begin
      failures++;
      $display("FAIL reset: arready=%b rvalid=%b rdata=%h rresp=%b irq=%b required 1 0 0 00 0",
               ARREADY, RVALID, RDATA, RRESP, result_irq_o);
    end
  endtask

  task automatic test_basic_read();
    @(negedge ACLK);
    ARADDR = BASE; ARVALID = 1'b1; RREADY = 1'b1;
    checks++;
    if (ARREADY !== 1'b1) begin failures++; $display("FAIL basic_arready: got %b required 1", ARREADY); end
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'd0 || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
      failures++;
      $display("FAIL basic_resp: rvalid=%b rdata=%h rresp=%b arready=%b required 1 0 00 0",
               RVALID, RDATA, RRESP, ARREADY);
    end
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 1'b0;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL basic_done: rvalid=%b arready=%b required 0 1", RVALID, ARREADY);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] d; logic [1:0] r; bit ok;
    randomize_counts();
    next_cnt[7] = 32'h0123;
    pulse_done(7);
    axi_read(BASE, 0, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h2 || r !== 2'b00) begin
      failures++; $display("FAIL snap_status: data=%h resp=%b ok=%0d required 2 00 1", d, r, ok);
    end
    checks++;
    if (result_irq_o !== 1'b1) begin failures++; $display("FAIL snap_irq_set: got %b required 1", result_irq_o); end
    axi_read(BASE + 32'h4, 0, 0, d, r, ok);
    m_done = 0; m_ovr = 0;
    checks++;
    if (!ok || d !== 32'd7 || r !== 2'b00) begin
      failures++; $display("FAIL snap_result: data=%h resp=%b ok=%0d required 7 00 1", d, r, ok);
    end
    checks++;
    if (result_irq_o !== 1'b0) begin failures++; $display("FAIL snap_irq_clr: got %b required 0", result_irq_o); end
    axi_read(BASE + 32'h11C, 0, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0123 || r !== 2'b00) begin
      failures++; $display("FAIL snap_cnt7: data=%h resp=%b ok=%0d required 0123 00 1", d, r, ok);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d; logic [1:0] r; bit ok;
    randomize_counts(); pulse_done(2);
    randomize_counts(); pulse_done(5);
    axi_read(BASE, 0, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h6) begin failures++; $display("FAIL ovr_status: data=%h ok=%0d required 6 1", d, ok); end
    axi_read(BASE + 32'h4, 1, 0, d, r, ok);
    m_done = 0; m_ovr = 0;
    checks++;
    if (!ok || d !== 32'd5) begin failures++; $display("FAIL ovr_result: data=%h ok=%0d required 5 1", d, ok); end
    axi_read(BASE, 0, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin failures++; $display("FAIL ovr_cleared: data=%h ok=%0d required 0 1", d, ok); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_d; logic [1:0] exp_r; bit clr;
    infer_busy_i = 1'b1;
    model_read(BASE, exp_d, exp_r, clr);
    @(negedge ACLK);
    ARADDR = BASE; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (RVALID !== 1'b1 || ARREADY !== 1'b0 || RDATA !== exp_d || RRESP !== exp_r) begin
        failures++;
        $display("FAIL stall_cycle%0d: rvalid=%b arready=%b rdata=%h required 1 0 %h",
                 i, RVALID, ARREADY, RDATA, exp_d);
      end
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 1'b0;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      failures++; $display("FAIL stall_complete: rvalid=%b arready=%b required 0 1", RVALID, ARREADY);
    end
    infer_busy_i = 1'b0;
  endtask

  task automatic test_decode_err();
    logic [31:0] d; logic [1:0] r; bit ok;
    logic [31:0] bad [4];
    bad[0] = BASE + 32'h008; bad[1] = BASE + 32'h002;
    bad[2] = BASE + 32'h128; bad[3] = BASE - 32'h4;
    randomize_counts(); pulse_done(4);
    for (int i = 0; i < 4; i++) begin
      axi_read(bad[i], i % 2, 0, d, r, ok);
      checks++;
      if (!ok || r !== 2'b10 || d !== 32'd0) begin
        failures++; $display("FAIL decerr_%h: data=%h resp=%b ok=%0d required 0 10 1", bad[i], d, r, ok);
      end
    end
    axi_read(BASE, 0, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h2 || result_irq_o !== 1'b1) begin
      failures++; $display("FAIL decerr_done_kept: status=%h irq=%b required 2 1", d, result_irq_o);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic [1:0] r; bit ok;
    randomize_counts(); pulse_done(3);
    randomize_counts(); pulse_done(8);
    randomize_counts();
    stage_done_inputs(9);
    axi_read(BASE + 32'h4, 2, 1, d, r, ok);
    m_done = 0; m_ovr = 0;
    model_snapshot(9);
    checks++;
    if (!ok || d !== 32'd8) begin failures++; $display("FAIL same_inflight: data=%h ok=%0d required 8 1", d, ok); end
    axi_read(BASE, 0, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h2 || result_irq_o !== 1'b1) begin
      failures++; $display("FAIL same_status: data=%h irq=%b required 2 1", d, result_irq_o);
    end
    axi_read(BASE + 32'h100 + 32'd4 * 32'd6, 0, 0, d, r, ok);
    checks++;
    if (!ok || d !== m_cnt[6]) begin
      failures++; $display("FAIL same_newcnt: data=%h required %h", d, m_cnt[6]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    ARADDR = BASE + 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
    ARESET  = 1'b1;
    @(negedge ACLK);
    checks++;
    if (RVALID !== 1'b0 || result_irq_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid: rvalid=%b irq=%b required 0 0", RVALID, result_irq_o);
    end
    ARESET = 1'b0;
    model_reset();
    @(negedge ACLK);
    checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      failures++; $display("FAIL reset_mid_idle: arready=%b rvalid=%b required 1 0", ARREADY, RVALID);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_d; logic [1:0] r, exp_r; bit ok, clr;
    for (int it = 0; it < 60; it++) begin
      infer_busy_i = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        randomize_counts();
        pulse_done($urandom_range(0, N_OUT - 1));
      end else begin
        case ($urandom_range(0, 5))
          0:       a = BASE;
          1:       a = BASE + 32'h4;
          2:       a = BASE + 32'h100 + 32'd4 * 32'($urandom_range(0, 11));
          3:       a = BASE + 32'd4 * 32'($urandom_range(0, 1023));
          4:       a = BASE + 32'($urandom_range(0, 4095));
          default: a = ($urandom_range(0, 1) == 0) ? 32'h0000_1FFC : 32'h0000_3000;
        endcase
        model_read(a, exp_d, exp_r, clr);
        axi_read(a, $urandom_range(0, 3), 0, d, r, ok);
        if (clr) begin m_done = 0; m_ovr = 0; end
        checks++;
        if (!ok || d !== exp_d || r !== exp_r || result_irq_o !== m_done) begin
          failures++;
          $display("FAIL rand_read[%0d] addr=%h: data=%h resp=%b ok=%0d irq=%b required %h %b 1 %b",
                   it, a, d, r, ok, result_irq_o, exp_d, exp_r, m_done);
        end
      end
    end
  endtask

  initial begin
    ARESET = 1'b1; ARADDR = '0; ARPROT = 3'b000; ARVALID = 1'b0; RREADY = 1'b0;
    infer_busy_i = 1'b0; infer_done_i = 1'b0; infer_class_i = '0; spike_cnt_i = '0;
    model_reset();
    test_reset();
    test_basic_read();
    test_snapshot();
    test_overrun();
    test_stall();
    test_decode_err();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
